// File: rtl/plane_ray_rob_pkg.sv
// Shared types for the ray/plane reorder buffer: tag width, pointer type and
// the per-entry payload that mirrors the fpnew result/status pair.
package plane_ray_rob_pkg;

    typedef logic [4:0] tag_t;

    localparam int unsigned RobDepth = 2**$bits(tag_t);
    localparam int unsigned RobWidth = 32;
    localparam int unsigned TagW     = $bits(tag_t);

    // One extra MSB on the pointers distinguishes full from empty.
    typedef logic [$clog2(RobDepth):0] rob_ptr_t;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

    typedef struct packed {
        logic [RobWidth-1:0] result;
        status_t             status;
    } rob_entry_t;

    function automatic logic ptr_full(input rob_ptr_t head, input rob_ptr_t tail);
        return (head[TagW-1:0] == tail[TagW-1:0]) && (head[TagW] != tail[TagW]);
    endfunction

endpackage

// File: rtl/plane_ray_rob.sv
// Tag-based reorder buffer: grants tags in order, accepts FMA/DIV results out
// of order, and releases them strictly in issue order.
module plane_ray_rob
    import plane_ray_rob_pkg::*;
#(
    parameter int unsigned DEPTH = RobDepth,
    parameter int unsigned WIDTH = RobWidth
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             alloc_valid_i,
    output logic             alloc_ready_o,
    output logic [4:0]       alloc_tag_o,

    input  logic             fma_valid_i,
    input  logic [4:0]       fma_tag_i,
    input  logic [WIDTH-1:0] fma_result_i,
    input  logic [4:0]       fma_status_i,
    output logic             fma_ready_o,

    input  logic             div_valid_i,
    input  logic [4:0]       div_tag_i,
    input  logic [WIDTH-1:0] div_result_i,
    input  logic [4:0]       div_status_i,
    output logic             div_ready_o,

    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [4:0]       out_tag_o,
    output logic [WIDTH-1:0] out_result_o,
    output logic [4:0]       out_status_o,

    output logic [5:0]       count_o,
    output logic             err_o
);

    // Handshakes: a transfer happens on any edge where valid && ready; the
    // response ports are always ready because every tag owns a reserved slot.

    rob_ptr_t         head_q, head_d;
    rob_ptr_t         tail_q, tail_d;
    logic [DEPTH-1:0] busy_q, busy_d;
    logic [DEPTH-1:0] done_q, done_d;
    logic             err_q, err_d;
    rob_entry_t       entries_q [DEPTH];

    tag_t       head_idx;
    tag_t       tail_idx;
    logic       full;
    logic       alloc_fire;
    logic       rel_fire;
    logic       head_ready;
    logic       fma_slot_open;
    logic       div_slot_open;
    logic       same_tag;
    logic       fma_wr;
    logic       div_wr;
    logic       err_set;
    rob_entry_t fma_entry;
    rob_entry_t div_entry;

    assign head_idx = head_q[TagW-1:0];
    assign tail_idx = tail_q[TagW-1:0];
    assign full     = ptr_full(head_q, tail_q);

    assign head_ready = busy_q[head_idx] && done_q[head_idx];
    assign alloc_fire = alloc_valid_i && !full;
    assign rel_fire   = head_ready && out_ready_i;

    assign fma_slot_open = busy_q[fma_tag_i] && !done_q[fma_tag_i];
    assign div_slot_open = busy_q[div_tag_i] && !done_q[div_tag_i];
    assign same_tag      = fma_valid_i && div_valid_i && (fma_tag_i == div_tag_i);

    // On a same-tag collision the FMA result wins and the DIV one is dropped.
    assign fma_wr  = fma_valid_i && fma_slot_open;
    assign div_wr  = div_valid_i && div_slot_open && !same_tag;
    assign err_set = (fma_valid_i && !fma_slot_open)
                   || (div_valid_i && !div_slot_open)
                   || same_tag;

    assign fma_entry = '{result: fma_result_i, status: status_t'(fma_status_i)};
    assign div_entry = '{result: div_result_i, status: status_t'(div_status_i)};

    always_comb begin
        busy_d = busy_q;
        done_d = done_q;
        head_d = head_q;
        tail_d = tail_q;
        err_d  = err_q | err_set;

        if (fma_wr) begin
            done_d[fma_tag_i] = 1'b1;
        end
        if (div_wr) begin
            done_d[div_tag_i] = 1'b1;
        end
        if (rel_fire) begin
            busy_d[head_idx] = 1'b0;
            done_d[head_idx] = 1'b0;
            head_d           = head_q + rob_ptr_t'(1);
        end
        // The tail slot is never busy when not full, so it cannot clash with
        // the release or a write-back above.
        if (alloc_fire) begin
            busy_d[tail_idx] = 1'b1;
            done_d[tail_idx] = 1'b0;
            tail_d           = tail_q + rob_ptr_t'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            busy_q <= '0;
            done_q <= '0;
            err_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            busy_q <= busy_d;
            done_q <= done_d;
            err_q  <= err_d;
            if (fma_wr) begin
                entries_q[fma_tag_i] <= fma_entry;
            end
            if (div_wr) begin
                entries_q[div_tag_i] <= div_entry;
            end
        end
    end

    assign alloc_ready_o = !full;
    assign alloc_tag_o   = tail_idx;
    assign fma_ready_o   = 1'b1;
    assign div_ready_o   = 1'b1;

    assign out_valid_o  = head_ready;
    assign out_tag_o    = head_idx;
    assign out_result_o = entries_q[head_idx].result;
    assign out_status_o = entries_q[head_idx].status;

    assign count_o = tail_q - head_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_plane_ray_rob.sv
// Directed bench for plane_ray_rob: queue-based reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_plane_ray_rob;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [4:0]  alloc_tag;
    logic        fma_valid, div_valid;
    logic [4:0]  fma_tag, div_tag;
    logic [31:0] fma_res, div_res;
    logic [4:0]  fma_stat, div_stat;
    logic        fma_ready, div_ready;
    logic        out_valid, out_ready;
    logic [4:0]  out_tag;
    logic [31:0] out_result;
    logic [4:0]  out_status;
    logic [5:0]  count;
    logic        err;

    plane_ray_rob dut (
        .clk_i(clk), .rst_ni(rst_n),
        .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready), .alloc_tag_o(alloc_tag),
        .fma_valid_i(fma_valid), .fma_tag_i(fma_tag), .fma_result_i(fma_res),
        .fma_status_i(fma_stat), .fma_ready_o(fma_ready),
        .div_valid_i(div_valid), .div_tag_i(div_tag), .div_result_i(div_res),
        .div_status_i(div_stat), .div_ready_o(div_ready),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_tag_o(out_tag),
        .out_result_o(out_result), .out_status_o(out_status),
        .count_o(count), .err_o(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: issue-ordered queue of live tags plus per-tag results.
    int          q[$];
    bit          m_done [32];
    logic [31:0] m_res  [32];
    logic [4:0]  m_stat [32];
    bit          m_err;
    int          m_next;

    bit [31:0]   live;
    int          rel_tag[$];
    logic [31:0] rel_res[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_q(input int t);
        foreach (q[i]) if (q[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int head_idx();
        return (m_next - q.size() + 32) % 32;
    endfunction

    initial begin : model
        bit head_ok, rel, alloc, same, f_ok, d_ok;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                foreach (m_done[i]) m_done[i] = 1'b0;
                m_err  = 1'b0;
                m_next = 0;
            end else begin
                head_ok = (q.size() > 0) && m_done[q[0]];
                rel     = head_ok && out_ready;
                alloc   = alloc_valid && (q.size() < 32);
                same    = fma_valid && div_valid && (fma_tag == div_tag);
                f_ok    = fma_valid && in_q(fma_tag) && !m_done[fma_tag];
                d_ok    = div_valid && !same && in_q(div_tag) && !m_done[div_tag];
                if ((fma_valid && !f_ok) || (div_valid && !d_ok)) m_err = 1'b1;
                if (f_ok) begin
                    m_done[fma_tag] = 1'b1; m_res[fma_tag] = fma_res; m_stat[fma_tag] = fma_stat;
                end
                if (d_ok) begin
                    m_done[div_tag] = 1'b1; m_res[div_tag] = div_res; m_stat[div_tag] = div_stat;
                end
                if (rel) begin
                    m_done[q[0]] = 1'b0;
                    void'(q.pop_front());
                end
                if (alloc) begin
                    q.push_back(m_next);
                    m_done[m_next] = 1'b0;
                    m_next = (m_next + 1) % 32;
                end
            end
        end
    end

    initial begin : compare
        bit exp_valid;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                live = '0;
            end else begin
                exp_valid = (q.size() > 0) && m_done[q[0]];
                chk("count", count, q.size());
                chk("alloc_ready", alloc_ready, q.size() < 32);
                chk("alloc_tag", alloc_tag, m_next);
                chk("out_valid", out_valid, exp_valid);
                chk("out_tag", out_tag, head_idx());
                chk("err", err, m_err);
                chk("rsp_ready", {fma_ready, div_ready}, 2'b11);
                if (exp_valid) begin
                    chk("out_result", out_result, m_res[q[0]]);
                    chk("out_status", out_status, m_stat[q[0]]);
                end
                if (out_valid && out_ready) begin
                    rel_tag.push_back(out_tag);
                    rel_res.push_back(out_result);
                    live[out_tag] = 1'b0;
                end
                if (alloc_valid && alloc_ready) begin
                    chk("tag_reuse", live[alloc_tag], 1'b0);
                    live[alloc_tag] = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        alloc_valid = 1'b0;
        fma_valid = 1'b0; fma_tag = '0; fma_res = '0; fma_stat = '0;
        div_valid = 1'b0; div_tag = '0; div_res = '0; div_stat = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rel_tag.delete();
        rel_res.delete();
    endtask

    task automatic fma_rsp(input int t, input logic [31:0] r, input logic [4:0] s);
        fma_valid = 1'b1; fma_tag = 5'(t); fma_res = r; fma_stat = s;
    endtask

    task automatic div_rsp(input int t, input logic [31:0] r, input logic [4:0] s);
        div_valid = 1'b1; div_tag = 5'(t); div_res = r; div_stat = s;
    endtask

    task automatic alloc_n(input int n);
        alloc_valid = 1'b1;
        repeat (n) tick();
        alloc_valid = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int pend[$];
        int issued, cyc, i1, i2;

        rst_n = 1'b0;
        clear_inputs();
        out_ready = 1'b0;
        #2;
        chk("rst_count", count, 6'd0);
        chk("rst_alloc_ready", alloc_ready, 1'b1);
        chk("rst_alloc_tag", alloc_tag, 5'd0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_tag", out_tag, 5'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_status", out_status, 5'd0);
        chk("rst_rsp_ready", {fma_ready, div_ready}, 2'b11);
        chk("rst_err", err, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // In-order completion.
        out_ready = 1'b1;
        alloc_valid = 1'b1;
        chk("t1_grant0", alloc_tag, 5'd0);
        tick();
        chk("t1_grant1", alloc_tag, 5'd1);
        tick();
        tick();
        alloc_valid = 1'b0;
        chk("t1_count3", count, 6'd3);
        fma_rsp(0, 32'h3F800000, 5'h00); tick();
        chk("t1_out0", {out_valid, out_tag, out_result}, {1'b1, 5'd0, 32'h3F800000});
        fma_rsp(1, 32'h40000000, 5'h01); tick();
        chk("t1_out1", {out_valid, out_tag, out_result, out_status}, {1'b1, 5'd1, 32'h40000000, 5'h01});
        fma_rsp(2, 32'h40400000, 5'h00); tick();
        chk("t1_out2", {out_valid, out_tag, out_result}, {1'b1, 5'd2, 32'h40400000});
        clear_inputs(); tick();
        chk("t1_empty", {out_valid, count}, {1'b0, 6'd0});
        chk("t1_nrel", rel_tag.size(), 3);
        if (rel_tag.size() == 3) begin
            chk("t1_order", {5'(rel_tag[0]), 5'(rel_tag[1]), 5'(rel_tag[2])}, {5'd0, 5'd1, 5'd2});
            chk("t1_res2", rel_res[2], 32'h40400000);
        end

        // Out-of-order return: FMA finishes tag 1 before DIV finishes tag 0.
        do_reset();
        out_ready = 1'b1;
        alloc_n(2);
        tick();
        fma_rsp(1, 32'h40A00000, 5'h00); tick(); clear_inputs();
        chk("t2_hold_a", out_valid, 1'b0);
        tick();
        chk("t2_hold_b", out_valid, 1'b0);
        div_rsp(0, 32'h3F000000, 5'h02); tick(); clear_inputs();
        chk("t2_out0", {out_valid, out_tag, out_result, out_status}, {1'b1, 5'd0, 32'h3F000000, 5'h02});
        tick();
        chk("t2_out1", {out_valid, out_tag, out_result}, {1'b1, 5'd1, 32'h40A00000});
        tick();
        chk("t2_empty", out_valid, 1'b0);

        // Simultaneous write-backs, then allocate and release in one cycle.
        do_reset();
        alloc_n(5);
        fma_rsp(3, 32'hAAAA0003, 5'h04);
        div_rsp(4, 32'hBBBB0004, 5'h08);
        tick(); clear_inputs();
        fma_rsp(0, 32'h00000010, 5'h00); tick(); clear_inputs();
        div_rsp(1, 32'h00000011, 5'h00); tick(); clear_inputs();
        fma_rsp(2, 32'h00000012, 5'h00); tick(); clear_inputs();
        chk("t4_err", err, 1'b0);
        chk("t4_count5", count, 6'd5);
        alloc_valid = 1'b1; out_ready = 1'b1;
        tick();
        alloc_valid = 1'b0;
        chk("t4_count_same", count, 6'd5);
        repeat (4) tick();
        chk("t4_nrel", rel_tag.size(), 5);
        if (rel_tag.size() == 5) begin
            chk("t4_rel3", {5'(rel_tag[3]), rel_res[3]}, {5'd3, 32'hAAAA0003});
            chk("t4_rel4", {5'(rel_tag[4]), rel_res[4]}, {5'd4, 32'hBBBB0004});
        end
        chk("t4_left", {out_valid, count}, {1'b0, 6'd1});

        // Response to an unallocated tag.
        do_reset();
        alloc_n(1);
        fma_rsp(7, 32'hDEADBEEF, 5'h1F); tick(); clear_inputs();
        chk("t5_err", err, 1'b1);
        chk("t5_state", {out_valid, count, alloc_tag}, {1'b0, 6'd1, 5'd1});

        // Same-tag collision: FMA value survives.
        do_reset();
        chk("t5_err_cleared", err, 1'b0);
        alloc_n(1);
        fma_rsp(0, 32'h11111111, 5'h00);
        div_rsp(0, 32'h22222222, 5'h00);
        tick(); clear_inputs();
        chk("t5_collide", {out_valid, out_result, err}, {1'b1, 32'h11111111, 1'b1});

        // Backpressure holds the head, then reset mid-stream.
        do_reset();
        alloc_n(2);
        fma_rsp(0, 32'h12345678, 5'h10);
        div_rsp(1, 32'h9ABCDEF0, 5'h01);
        tick(); clear_inputs();
        for (int k = 0; k < 5; k++) begin
            chk("t6_stall", {out_valid, out_tag, out_result, out_status},
                {1'b1, 5'd0, 32'h12345678, 5'h10});
            tick();
        end
        fma_rsp(9, 32'h0, 5'h0); tick(); clear_inputs();
        chk("t6_err_set", {err, count}, {1'b1, 6'd2});
        rst_n = 1'b0;
        #1;
        chk("t6_async_rst", {count, out_valid, err, alloc_ready}, {6'd0, 1'b0, 1'b0, 1'b1});
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill, wrap and a longer mixed run.
        do_reset();
        out_ready = 1'b1;
        alloc_n(32);
        chk("t3_full", {alloc_ready, count}, {1'b0, 6'd32});
        alloc_valid = 1'b1; tick(); alloc_valid = 1'b0;
        chk("t3_refused", {count, alloc_tag}, {6'd32, 5'd0});
        fma_rsp(0, 32'hCAFE0000, 5'h00); tick(); clear_inputs();
        chk("t3_not_yet", {alloc_ready, out_valid}, {1'b0, 1'b1});
        tick();
        chk("t3_ready_back", {alloc_ready, count, alloc_tag}, {1'b1, 6'd31, 5'd0});

        issued = 32;
        cyc = 0;
        while (issued < 100 && cyc < 3000) begin
            clear_inputs();
            alloc_valid = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            pend.delete();
            foreach (q[i]) if (!m_done[q[i]]) pend.push_back(q[i]);
            if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
                i1 = $urandom_range(0, pend.size() - 1);
                fma_rsp(pend[i1], $urandom, 5'($urandom_range(0, 31)));
                if (pend.size() > 1 && $urandom_range(0, 1) != 0) begin
                    i2 = (i1 + 1 + $urandom_range(0, pend.size() - 2)) % pend.size();
                    div_rsp(pend[i2], $urandom, 5'($urandom_range(0, 31)));
                end
            end
            if (alloc_valid && q.size() < 32) issued++;
            tick();
            cyc++;
        end
        chk("t3_ops_done", issued >= 100, 1'b1);

        clear_inputs();
        out_ready = 1'b1;
        cyc = 0;
        while (q.size() > 0 && cyc < 500) begin
            clear_inputs();
            pend.delete();
            foreach (q[i]) if (!m_done[q[i]]) pend.push_back(q[i]);
            if (pend.size() > 0) fma_rsp(pend[pend.size() - 1], $urandom, 5'h00);
            tick();
            cyc++;
        end
        clear_inputs();
        tick();
        chk("t3_drained", {count, out_valid, err}, {6'd0, 1'b0, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/plane_ray_rob.md
# plane_ray_rob

Tag-based reorder buffer sitting between the ray/plane intersection sequencer and the fpnew slices (2-cycle FMA, 4-cycle DIV). It hands out `tag_t` tags at issue, accepts tagged results from both slices out of order, and releases them strictly in issue order. It is the response end of the tag protocol that the FPU configuration defines.

## Interface
- `DEPTH`, default 32: entries; must equal 2**$bits(tag_t).
- `WIDTH`, default 32: result width; matches FPU `Features.Width`.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `alloc_valid_i` in 1: sequencer requests a tag.
- `alloc_ready_o` out 1: a free slot exists; the tag is taken when `alloc_valid_i && alloc_ready_o`.
- `alloc_tag_o` out 5: tag granted, equal to the tail index.
- `fma_valid_i` in 1: FMA slice result valid.
- `fma_tag_i` in 5: tag of the FMA result.
- `fma_result_i` in WIDTH: FMA result data.
- `fma_status_i` in 5: fpnew `status_t` for the FMA result.
- `div_valid_i`, `div_tag_i`, `div_result_i`, `div_status_i`: same set for the DIV slice.
- `fma_ready_o`, `div_ready_o` out 1: always 1 outside reset; the slot is pre-reserved.
- `out_valid_o` out 1: head entry complete.
- `out_ready_i` in 1: consumer accepts the head entry.
- `out_tag_o` out 5: head tag.
- `out_result_o` out WIDTH: head result.
- `out_status_o` out 5: head status.
- `count_o` out 6: in-flight entries, 0..DEPTH.
- `err_o` out 1: sticky protocol-error flag.

## Operation
- State:
  - `head` and `tail` pointers, 6 bits each; the MSB is the wrap bit.
  - Per-entry `busy`, `done`, result and status.
- Full: `head[4:0]==tail[4:0]` and the wrap bits differ. Empty: the pointers are equal.
- Allocate: `alloc_ready_o = !full`, from registered state only. There is no bypass from a same-cycle release.
  - On handshake: set `busy[tail]`, clear `done[tail]`, `tail++`.
- Write-back: a valid response to a tag with `busy=1, done=0` stores result and status and sets `done`.
- Response errors set `err_o`:
  - A response to a tag with `busy=0` or `done=1` is dropped.
  - FMA and DIV both valid with the same tag: FMA is written, DIV is dropped.
  - FMA and DIV with different tags in the same cycle are both written.
- Release:
  - `out_valid_o = busy[head] && done[head]`.
  - `out_*` are driven combinationally from the head entry registers.
  - On `out_valid_o && out_ready_i`: clear `busy[head]` and `done[head]`, `head++`.
- `count_o = tail - head` (6-bit subtraction).
- Simultaneous allocate and release: both happen; count is unchanged.
- Pointer wrap: index 31 → 0 with the wrap bit toggled. A tag is reused only after its release.
- `err_o` clears only on reset.

## Timing
- Reset, asynchronous and immediate:
  - Pointers 0, all `busy`/`done` 0, `err_o` 0.
  - Hence `out_valid_o` 0, `count_o` 0, `alloc_ready_o` 1, `fma_ready_o`/`div_ready_o` 1, `alloc_tag_o` 0.
  - `out_result_o`, `out_status_o` and `out_tag_o` read 0.
- Reset mid-operation discards every in-flight entry. The sequencer and FPU must be reset together.
- Response at edge N → `out_valid_o` high from edge N onward (visible in cycle N+1), if that tag is the head. Minimum response-to-output latency is 1 cycle.
- Allocate at edge N: `count_o` and `alloc_tag_o` update in cycle N+1.
- The 33rd allocation without any release sees `alloc_ready_o=0`. It becomes ready the cycle after the first release.
- `out_*` hold stable while `out_valid_o && !out_ready_i`.

## Structure
- Add to `plane_ray_int_defines`:
  - `localparam int unsigned RobDepth = 2**$bits(tag_t)`.
  - `typedef logic [$clog2(RobDepth):0] rob_ptr_t`.
  - `typedef struct packed { logic [31:0] result; fpnew_pkg::status_t status; } rob_entry_t`.
- No sub-module. Storage is a flop array of `rob_entry_t` plus `busy`/`done` vectors; pointer logic is inline.

## Test plan
- In-order completion: allocate tags 0,1,2; FMA returns 0,1,2 with results 0x3F800000, 0x40000000, 0x40400000 → released in order 0,1,2, each one cycle after write-back.
- Reordering: allocate 0 (DIV) and 1 (FMA); FMA returns tag 1 at cycle 3, DIV returns tag 0 at cycle 5 → tag 0 out at cycle 6, tag 1 at cycle 7 (`out_ready_i=1`); `out_valid_o` stays 0 before cycle 6.
- Full and wrap:
  - Allocate 32 → `alloc_ready_o=0`, `count_o=32`.
  - Complete and release tag 0 → ready returns the next cycle and the next grant is tag 0.
  - Run 100 ops total; every tag reuse occurs only after its release.
- Simultaneous events:
  - FMA tag 3 and DIV tag 4 in the same cycle → both stored.
  - Allocate and release in the same cycle → `count_o` unchanged.
- Errors:
  - Response to an unallocated tag 7 → dropped, `err_o=1`, state otherwise unchanged.
  - Same-tag FMA/DIV collision → FMA value (0x11111111) is released, `err_o=1`.
- Backpressure and reset:
  - Hold `out_ready_i=0` for 5 cycles → `out_*` stable.
  - Assert `rst_ni=0` mid-stream → `count_o=0`, `out_valid_o=0` immediately, `err_o=0`.
